// File: rtl/alu_pkg.sv
// Shared ALU select encodings and arbiter state encoding.
package alu_pkg;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned SelWidth  = 4;

   // Codes outside this set (0100, 1010-1111) are forwarded as-is; the ALU returns 0 for them.
   typedef enum logic [SelWidth-1:0] {
      AluForward = 4'b0000,
      AluAdd     = 4'b0001,
      AluAnd     = 4'b0010,
      AluOr      = 4'b0011,
      AluMul     = 4'b0101,
      AluXor     = 4'b0110,
      AluSll     = 4'b0111,
      AluSrl     = 4'b1000,
      AluSra     = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StResp = 2'b10
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic: valid vector plus last grant index to a one-hot grant.
module rr_arbiter2 #(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic [1:0] valid,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   // A lone requester always wins; contention goes to the other side of last_gnt, or to 0.
   always_comb begin
      gnt = valid;
      if (valid == 2'b11) begin
         if (RR_ENABLE) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
         end else begin
            gnt = 2'b01;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation in flight at a time.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 REQ_VALID_0,
   input  logic                 REQ_VALID_1,
   output logic                 REQ_READY_0,
   output logic                 REQ_READY_1,
   input  logic [DataWidth-1:0] REQ_DATA1_0,
   input  logic [DataWidth-1:0] REQ_DATA2_0,
   input  logic [DataWidth-1:0] REQ_DATA1_1,
   input  logic [DataWidth-1:0] REQ_DATA2_1,
   input  logic [SelWidth-1:0]  REQ_SELECT_0,
   input  logic [SelWidth-1:0]  REQ_SELECT_1,
   output logic                 RSP_VALID_0,
   output logic                 RSP_VALID_1,
   input  logic                 RSP_READY_0,
   input  logic                 RSP_READY_1,
   output logic [DataWidth-1:0] RSP_RESULT_0,
   output logic [DataWidth-1:0] RSP_RESULT_1,
   output logic                 RSP_ZERO_0,
   output logic                 RSP_ZERO_1,
   output logic [DataWidth-1:0] ALU_DATA1,
   output logic [DataWidth-1:0] ALU_DATA2,
   output logic [SelWidth-1:0]  ALU_SELECT,
   input  logic [DataWidth-1:0] ALU_RESULT,
   input  logic                 ALU_ZERO,
   output logic                 BUSY
);

   arb_state_e state_q, state_d;
   logic       last_gnt_q, last_gnt_d;   // index of the most recently accepted requester
   logic       owner_q, owner_d;         // index of the requester currently in flight

   logic [DataWidth-1:0] alu_data1_q, alu_data1_d;
   logic [DataWidth-1:0] alu_data2_q, alu_data2_d;
   logic [SelWidth-1:0]  alu_select_q, alu_select_d;

   logic [1:0]                rsp_valid_q, rsp_valid_d;
   logic [1:0][DataWidth-1:0] rsp_result_q, rsp_result_d;
   logic [1:0]                rsp_zero_q, rsp_zero_d;

   logic [1:0] gnt;
   logic [1:0] req_ready;
   logic [1:0] rsp_ready;
   logic       accept;
   logic       accept_idx;

   rr_arbiter2 #(
      .RR_ENABLE (RR_ENABLE)
   ) u_rr_arbiter2 (
      .valid    ({REQ_VALID_1, REQ_VALID_0}),
      .last_gnt (last_gnt_q),
      .gnt      (gnt)
   );

   // Grant is only offered while idle; it already implies the matching valid.
   always_comb begin
      req_ready  = (state_q == StIdle) ? gnt : 2'b00;
      accept     = |req_ready;
      accept_idx = req_ready[1];
      rsp_ready  = {RSP_READY_1, RSP_READY_0};
   end

   // Next-state logic: accept in idle, capture ALU output in exec, handshake in resp.
   always_comb begin
      state_d      = state_q;
      last_gnt_d   = last_gnt_q;
      owner_d      = owner_q;
      alu_data1_d  = alu_data1_q;
      alu_data2_d  = alu_data2_q;
      alu_select_d = alu_select_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               alu_data1_d  = accept_idx ? REQ_DATA1_1 : REQ_DATA1_0;
               alu_data2_d  = accept_idx ? REQ_DATA2_1 : REQ_DATA2_0;
               alu_select_d = accept_idx ? REQ_SELECT_1 : REQ_SELECT_0;
               owner_d      = accept_idx;
               last_gnt_d   = accept_idx;
               state_d      = StExec;
            end
         end
         StExec: begin
            rsp_result_d[owner_q] = ALU_RESULT;
            rsp_zero_d[owner_q]   = ALU_ZERO;
            rsp_valid_d[owner_q]  = 1'b1;
            state_d               = StResp;
         end
         StResp: begin
            if (rsp_ready[owner_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= StIdle;
         last_gnt_q   <= 1'b1;
         owner_q      <= 1'b0;
         alu_data1_q  <= '0;
         alu_data2_q  <= '0;
         alu_select_q <= '0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_gnt_q   <= last_gnt_d;
         owner_q      <= owner_d;
         alu_data1_q  <= alu_data1_d;
         alu_data2_q  <= alu_data2_d;
         alu_select_q <= alu_select_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign REQ_READY_0  = req_ready[0];
   assign REQ_READY_1  = req_ready[1];
   assign RSP_VALID_0  = rsp_valid_q[0];
   assign RSP_VALID_1  = rsp_valid_q[1];
   assign RSP_RESULT_0 = rsp_result_q[0];
   assign RSP_RESULT_1 = rsp_result_q[1];
   assign RSP_ZERO_0   = rsp_zero_q[0];
   assign RSP_ZERO_1   = rsp_zero_q[1];
   assign ALU_DATA1    = alu_data1_q;
   assign ALU_DATA2    = alu_data2_q;
   assign ALU_SELECT   = alu_select_q;
   assign BUSY         = (state_q != StIdle);

endmodule
